// File: rtl/mem_responder_if.sv
// mem_responder_if: CPU port, host load stream and host dump stream of the
// memory responder, bundled so the top level only carries clk/reset plus one bus.
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 9
);
    logic [ADDR_WIDTH-1:0] cpu_raddr;
    logic [ADDR_WIDTH-1:0] cpu_waddr;
    logic [7:0]            cpu_data_in;
    logic                  cpu_write;
    logic [7:0]            cpu_data_out;
    logic                  cpu_ready;
    logic                  cpu_reset;
    logic                  cpu_halted;
    logic                  load_start;
    logic                  dump_start;
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_last;
    logic                  rx_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_last;
    logic                  tx_ready;
    logic                  busy;

    // The responder itself.
    modport slave (
        input  cpu_raddr, cpu_waddr, cpu_data_in, cpu_write, cpu_halted,
        input  load_start, dump_start, rx_data, rx_valid, rx_last, tx_ready,
        output cpu_data_out, cpu_ready, cpu_reset, rx_ready,
        output tx_data, tx_valid, tx_last, busy
    );

    // The CPU + host side driving the responder.
    modport master (
        output cpu_raddr, cpu_waddr, cpu_data_in, cpu_write, cpu_halted,
        output load_start, dump_start, rx_data, rx_valid, rx_last, tx_ready,
        input  cpu_data_out, cpu_ready, cpu_reset, rx_ready,
        input  tx_data, tx_valid, tx_last, busy
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: byte memory shared between a CPU and a host.
// The host loads a program (LOAD), the CPU runs out of reset (RUN), and once
// the CPU halts a fixed window is streamed back to the host (DUMP_RD/DUMP_TX).
// Optional macro WRITE_FORWARD_EN: in RUN a same-address CPU write is
// forwarded to cpu_data_out instead of returning the old contents.
module mem_responder #(
    parameter int ADDR_WIDTH = 9,
    parameter int DUMP_BASE  = 2,
    parameter int DUMP_LEN   = 64
) (
    input  logic               clk,
    input  logic               reset,
    mem_responder_if.slave     bus
);
    localparam int                    DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DUMP_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(DUMP_BASE);
    localparam logic [ADDR_WIDTH-1:0] TOP_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_RUN, S_DUMP_RD, S_DUMP_TX
    } state_t;

    logic [7:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [7:0]            cpu_data_q, cpu_data_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  tx_last_q, tx_last_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  busy_q, busy_d;

    // Single write port: LOAD and RUN never overlap, so host and CPU share it.
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_wa;
    logic [7:0]            mem_wd;

    // Next-state, memory write select and next registered outputs.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = idx_q;
        tx_data_d  = tx_data_q;
        cpu_data_d = mem[bus.cpu_raddr];
        mem_we     = 1'b0;
        mem_wa     = bus.cpu_waddr;
        mem_wd     = bus.cpu_data_in;

        case (state_q)
            S_IDLE: begin
                if (bus.load_start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                end else if (bus.dump_start) begin
                    state_d = S_DUMP_RD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                if (bus.rx_valid && rx_ready_q) begin
                    mem_we = 1'b1;
                    mem_wa = ptr_q;
                    mem_wd = bus.rx_data;
                    // Top address ends the load rather than wrapping the pointer.
                    if (bus.rx_last || ptr_q == TOP_ADDR) state_d = S_RUN;
                    else                                   ptr_d   = ptr_q + 1'b1;
                end
            end
            S_RUN: begin
                mem_we = bus.cpu_write;
`ifdef WRITE_FORWARD_EN
                if (bus.cpu_write && bus.cpu_raddr == bus.cpu_waddr)
                    cpu_data_d = bus.cpu_data_in;
`endif
                if (bus.cpu_halted) begin
                    state_d = S_DUMP_RD;
                    idx_d   = '0;
                end
            end
            S_DUMP_RD: begin
                // Address adds in ADDR_WIDTH bits, so the window wraps naturally.
                tx_data_d = mem[BASE + idx_q];
                state_d   = S_DUMP_TX;
            end
            S_DUMP_TX: begin
                if (bus.tx_ready) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_DUMP_RD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        cpu_ready_d = (state_d == S_RUN);
        cpu_reset_d = (state_d != S_RUN);
        rx_ready_d  = (state_d == S_LOAD);
        busy_d      = (state_d != S_IDLE);
        tx_valid_d  = (state_d == S_DUMP_TX);
        tx_last_d   = (state_d == S_DUMP_TX) && (idx_d == LAST_IDX);
    end

    // FSM state, pointers and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            cpu_data_q  <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            tx_last_q   <= 1'b0;
            rx_ready_q  <= 1'b0;
            cpu_ready_q <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            cpu_data_q  <= cpu_data_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            tx_last_q   <= tx_last_d;
            rx_ready_q  <= rx_ready_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
        end
    end

    // Memory array: never cleared, and a write is suppressed during reset.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) mem[mem_wa] <= mem_wd;
    end

    assign bus.cpu_data_out = cpu_data_q;
    assign bus.cpu_ready    = cpu_ready_q;
    assign bus.cpu_reset    = cpu_reset_q;
    assign bus.rx_ready     = rx_ready_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.tx_valid     = tx_valid_q;
    assign bus.tx_last      = tx_last_q;
    assign bus.busy         = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized stimulus against a flat array model of memory.
module tb_mem_responder;
    localparam int AW        = 9;
    localparam int DEPTH     = 1 << AW;
    localparam int DUMP_BASE = 2;
    localparam int DUMP_LEN  = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [7:0] model_mem [DEPTH];

    mem_responder_if #(.ADDR_WIDTH(AW)) bus();

    mem_responder #(
        .ADDR_WIDTH(AW), .DUMP_BASE(DUMP_BASE), .DUMP_LEN(DUMP_LEN)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [AW-1:0] a, input logic [7:0] d);
        bus.cpu_waddr = a; bus.cpu_data_in = d; bus.cpu_write = 1'b1;
        step();
        bus.cpu_write = 1'b0;
        model_mem[a] = d;
    endtask

    task automatic cpu_rd_chk(input string tag, input logic [AW-1:0] a);
        bus.cpu_raddr = a;
        step();
        chk(tag, bus.cpu_data_out, model_mem[a]);
    endtask

    // Load a byte stream from address 0; optional rx_last on the final byte.
    task automatic load_stream(input logic [7:0] data[$], input bit use_last, input bit both);
        bus.load_start = 1'b1; bus.dump_start = both;
        step();
        bus.load_start = 1'b0; bus.dump_start = 1'b0;
        chk("load_tx_valid", bus.tx_valid, 0);
        foreach (data[k]) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.rx_valid = 1'b0;
                step();
            end
            chk("load_rx_ready", bus.rx_ready, 1);
            bus.rx_valid = 1'b1; bus.rx_data = data[k];
            bus.rx_last  = use_last && (k == data.size() - 1);
            step();
            model_mem[k] = data[k];
        end
        bus.rx_valid = 1'b0; bus.rx_last = 1'b0;
        chk("run_cpu_ready", bus.cpu_ready, 1);
        chk("run_cpu_reset", bus.cpu_reset, 0);
        chk("run_rx_ready", bus.rx_ready, 0);
    endtask

    // Random CPU traffic in RUN; every cycle's read data is predicted.
    task automatic cpu_traffic(input int n);
        logic [AW-1:0] ra, wa;
        logic [7:0] d, exp;
        bit we;
        for (int k = 0; k < n; k++) begin
            ra = AW'($urandom);
            wa = ($urandom_range(0, 3) == 0) ? ra : AW'($urandom);
            we = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            exp = model_mem[ra];
`ifdef WRITE_FORWARD_EN
            if (we && ra == wa) exp = d;
`endif
            bus.cpu_raddr = ra; bus.cpu_waddr = wa; bus.cpu_write = we; bus.cpu_data_in = d;
            step();
            if (we) model_mem[wa] = d;
            chk("cpu_rd", bus.cpu_data_out, exp);
        end
        bus.cpu_write = 1'b0;
    endtask

    // Accept dump bytes until the last one or nmax bytes; tog gives 1/0 tx_ready.
    task automatic dump_collect(input int nmax, input bit tog);
        int n = 0;
        int cyc = 0;
        bit done = 1'b0;
        bit phase = 1'b1;
        bit rdy;
        logic [7:0] pd;
        logic pv, pl;
        while (!done && cyc < 2000) begin
            rdy = tog ? phase : 1'($urandom_range(0, 1));
            phase = !phase;
            bus.tx_ready = rdy;
            bus.load_start = bus.tx_valid ? 1'($urandom_range(0, 1)) : 1'b0;
            pv = bus.tx_valid; pd = bus.tx_data; pl = bus.tx_last;
            step();
            cyc++;
            if (pv && rdy) begin
                chk("dump_data", pd, model_mem[(DUMP_BASE + n) % DEPTH]);
                chk("dump_last", pl, (n == DUMP_LEN - 1));
                n++;
                if (n == DUMP_LEN || n == nmax) done = 1'b1;
            end else if (pv) begin
                chk("dump_hold_valid", bus.tx_valid, 1);
                chk("dump_hold_data", bus.tx_data, pd);
            end
        end
        bus.tx_ready = 1'b0; bus.load_start = 1'b0;
        if (!done) chk("dump_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] exp;

        bus.cpu_raddr = '0; bus.cpu_waddr = '0; bus.cpu_data_in = '0; bus.cpu_write = 1'b0;
        bus.cpu_halted = 1'b0; bus.load_start = 1'b0; bus.dump_start = 1'b0;
        bus.rx_data = '0; bus.rx_valid = 1'b0; bus.rx_last = 1'b0; bus.tx_ready = 1'b0;

        // Reset state.
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_cpu_reset", bus.cpu_reset, 1);
        chk("rst_cpu_ready", bus.cpu_ready, 0);
        chk("rst_tx_valid", bus.tx_valid, 0);
        chk("rst_tx_last", bus.tx_last, 0);
        chk("rst_rx_ready", bus.rx_ready, 0);

        // cpu_halted is meaningless in IDLE.
        bus.cpu_halted = 1'b1; step(); bus.cpu_halted = 1'b0; step();
        chk("idle_halt_ignored", bus.busy, 0);

        // Full-memory load with both starts asserted; ends after address 0x1FF.
        q = {};
        for (int k = 0; k < DEPTH; k++) q.push_back(8'($urandom));
        load_stream(q, 1'b0, 1'b1);

        cpu_traffic(300);

        // CPU write then read: one cycle of read latency.
        cpu_wr(AW'(9'h100), 8'h5A);
        cpu_rd_chk("cpu_latency", AW'(9'h100));

        // Same-address write and read.
        cpu_wr(AW'(9'h033), 8'h11);
        bus.cpu_raddr = AW'(9'h033); bus.cpu_waddr = AW'(9'h033);
        bus.cpu_data_in = 8'h77; bus.cpu_write = 1'b1;
        step();
        bus.cpu_write = 1'b0;
`ifdef WRITE_FORWARD_EN
        exp = 8'h77;
`else
        exp = 8'h11;
`endif
        chk("same_addr", bus.cpu_data_out, exp);
        model_mem[9'h033] = 8'h77;
        cpu_rd_chk("same_addr_after", AW'(9'h033));

        // Dump after halt, tx_ready toggling 1/0.
        for (int k = 0; k < DUMP_LEN; k++) cpu_wr(AW'(DUMP_BASE + k), 8'(k));
        bus.cpu_halted = 1'b1; step(); bus.cpu_halted = 1'b0;
        chk("halt_cpu_reset", bus.cpu_reset, 1);
        dump_collect(DUMP_LEN, 1'b1);
        chk("dump_end_valid", bus.tx_valid, 0);
        chk("dump_end_busy", bus.busy, 0);

        // CPU write outside RUN has no effect.
        exp = model_mem[5];
        bus.cpu_waddr = AW'(5); bus.cpu_data_in = ~exp; bus.cpu_write = 1'b1;
        step();
        bus.cpu_write = 1'b0;
        cpu_rd_chk("idle_write_ignored", AW'(5));

        // Short load with rx_last.
        q = {8'h12, 8'h34, 8'hAB};
        load_stream(q, 1'b1, 1'b0);
        cpu_rd_chk("load_m0", AW'(0));
        cpu_rd_chk("load_m1", AW'(1));
        cpu_rd_chk("load_m2", AW'(2));
        chk("load_m2_val", bus.cpu_data_out, 8'hAB);

        cpu_traffic(100);

        // Reset in the middle of a dump, then a fresh dump from the base.
        bus.cpu_halted = 1'b1; step(); bus.cpu_halted = 1'b0;
        dump_collect(10, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_tx_valid", bus.tx_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_cpu_reset", bus.cpu_reset, 1);
        chk("mid_rst_data_out", bus.cpu_data_out, 0);
        bus.dump_start = 1'b1; step(); bus.dump_start = 1'b0;
        chk("redump_busy", bus.busy, 1);
        dump_collect(DUMP_LEN, 1'b0);
        chk("redump_end_busy", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
